// File: rtl/ql_bl_wl_config_loader.sv
// rtl/ql_bl_wl_config_loader.sv - beat-to-row BL/WL fabric configuration loader
// Optional trailer CRC check is built when CFG_LOADER_CRC_EN is defined.
module ql_bl_wl_config_loader #(
  parameter int BL_W     = 514,
  parameter int WL_W     = 407,
  parameter int DATA_W   = 32,
  parameter int WL_PULSE = 2
) (
  input  logic              clk,
  input  logic              global_reset,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [0:BL_W-1]   bl,
  output logic [0:WL_W-1]   wl,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_error
);

  localparam int BEATS   = (BL_W + DATA_W - 1) / DATA_W;
  localparam int ROW_W   = (WL_W > 1) ? $clog2(WL_W) : 1;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PULSE_W = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_HOLD,
    S_DONE
`ifdef CFG_LOADER_CRC_EN
    , S_CHECK
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [PULSE_W-1:0]   pulse_q, pulse_d;
  logic [0:BL_W-1]      bl_q, bl_d;
  logic [0:WL_W-1]      wl_q, wl_d;
  logic                 done_q, done_d;
  logic [0:BEATS*DATA_W-1] wide;
  logic                 accept;

`ifdef CFG_LOADER_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic        err_q, err_d;

  // CRC-16-CCITT, one data bit per shift, LSB of the beat first
  function automatic logic [15:0] crc_feed(input logic [15:0] c, input logic [DATA_W-1:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < DATA_W; i++) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction
`endif

  always_comb begin
    s_ready = (state_q == S_LOAD);
`ifdef CFG_LOADER_CRC_EN
    if (state_q == S_CHECK) s_ready = 1'b1;
`endif
  end

  assign accept = s_valid & s_ready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    beat_d  = beat_q;
    pulse_d = pulse_q;
    done_d  = done_q;
    wide    = '0;
    wide[0:BL_W-1] = bl_q;
`ifdef CFG_LOADER_CRC_EN
    crc_d = crc_q;
    err_d = err_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          row_d   = '0;
          beat_d  = '0;
          done_d  = 1'b0;
`ifdef CFG_LOADER_CRC_EN
          crc_d = 16'hFFFF;
          err_d = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (accept) begin
          // Bits landing past BL_W-1 go into the padding of wide and are dropped
          for (int k = 0; k < BEATS; k++) begin
            if (beat_q == BEAT_W'(k)) begin
              for (int i = 0; i < DATA_W; i++) begin
                wide[k*DATA_W+i] = s_data[i];
              end
            end
          end
`ifdef CFG_LOADER_CRC_EN
          crc_d = crc_feed(crc_q, s_data);
`endif
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            state_d = S_WRITE;
            pulse_d = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (pulse_q == PULSE_W'(WL_PULSE - 1)) begin
          state_d = S_HOLD;
        end else begin
          pulse_d = pulse_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (row_q == ROW_W'(WL_W - 1)) begin
`ifdef CFG_LOADER_CRC_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
`endif
        end else begin
          row_d   = row_q + 1'b1;
          beat_d  = '0;
          state_d = S_LOAD;
        end
      end
`ifdef CFG_LOADER_CRC_EN
      S_CHECK: begin
        if (accept) begin
          err_d   = (s_data[15:0] != crc_q);
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    bl_d = wide[0:BL_W-1];
    // wl is registered off the next state so it rises the cycle after the last beat
    wl_d = '0;
    if (state_d == S_WRITE) wl_d[row_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (global_reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      beat_q  <= '0;
      pulse_q <= '0;
      bl_q    <= '0;
      wl_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      beat_q  <= beat_d;
      pulse_q <= pulse_d;
      bl_q    <= bl_d;
      wl_q    <= wl_d;
      done_q  <= done_d;
    end
  end

`ifdef CFG_LOADER_CRC_EN
  always_ff @(posedge clk) begin
    if (global_reset) begin
      crc_q <= 16'hFFFF;
      err_q <= 1'b0;
    end else begin
      crc_q <= crc_d;
      err_q <= err_d;
    end
  end
  assign cfg_error = err_q;
`else
  assign cfg_error = 1'b0;
`endif

  assign bl       = bl_q;
  assign wl       = wl_q;
  assign cfg_done = done_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_ql_bl_wl_config_loader.sv
// tb/tb_ql_bl_wl_config_loader.sv - directed bench for ql_bl_wl_config_loader
module tb_ql_bl_wl_config_loader;

  localparam int BL_W     = 40;
  localparam int WL_W     = 3;
  localparam int DATA_W   = 16;
  localparam int WL_PULSE = 2;
  localparam int BEATS    = 3;
  localparam int NBEATS   = BEATS * WL_W;

  logic              clk = 1'b0;
  logic              global_reset;
  logic              start;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [0:BL_W-1]   bl;
  logic [0:WL_W-1]   wl;
  logic              busy;
  logic              cfg_done;
  logic              cfg_error;

  int total = 0;
  int bad   = 0;

  logic [15:0]     beat_mem [0:NBEATS-1];
  logic [0:BL_W-1] cap_bl0;
  logic [0:BL_W-1] exp_bl;

  ql_bl_wl_config_loader #(
    .BL_W(BL_W), .WL_W(WL_W), .DATA_W(DATA_W), .WL_PULSE(WL_PULSE)
  ) dut (
    .clk(clk), .global_reset(global_reset), .start(start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .bl(bl), .wl(wl), .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:BL_W-1] row_bits(input int r);
    logic [0:BL_W-1] v;
    for (int i = 0; i < BL_W; i++) v[i] = beat_mem[r*BEATS + i/DATA_W][i%DATA_W];
    return v;
  endfunction

  function automatic logic [0:WL_W-1] onehot(input int r);
    logic [0:WL_W-1] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

`ifdef CFG_LOADER_CRC_EN
  function automatic logic [15:0] crc_model();
    logic [15:0] c;
    logic [15:0] d;
    c = 16'hFFFF;
    for (int b = 0; b < NBEATS; b++) begin
      d = beat_mem[b];
      for (int i = 0; i < 16; i++) begin
        if (c[15] ^ d[i]) c = (c << 1) ^ 16'h1021;
        else c = c << 1;
      end
    end
    return c;
  endfunction

  task automatic send_trailer(input string tag, input logic [15:0] t, input logic exp_err);
    s_valid = 1'b1;
    s_data  = t;
    step;
    s_valid = 1'b0;
    chk({tag, " done"}, cfg_done, 1);
    chk({tag, " error"}, cfg_error, exp_err);
    chk({tag, " busy"}, busy, 0);
  endtask
`endif

  // Feeds beat_mem row by row and checks every WL pulse window cycle by cycle
  task automatic do_load(input bit gap, input string tag);
    int  acc_n;
    int  row;
    int  cyc;
    bit  acc;
    acc_n = 0;
    row   = 0;
    cyc   = 0;
    start = 1'b1;
    step;
    start = 1'b0;
    chk({tag, " busy after start"}, busy, 1);
    chk({tag, " ready after start"}, s_ready, 1);
    chk({tag, " done cleared"}, cfg_done, 0);
    chk({tag, " error cleared"}, cfg_error, 0);
    while (row < WL_W && cyc < 300) begin
      s_valid = gap ? (cyc % 2 == 0) : 1'b1;
      s_data  = beat_mem[acc_n];
      acc     = s_valid && s_ready;
      step;
      cyc++;
      s_valid = 1'b0;
      if (acc) begin
        acc_n++;
        if (acc_n % BEATS == 0) begin
          exp_bl = row_bits(row);
          chk($sformatf("%s wl rise row%0d", tag, row), wl, onehot(row));
          chk($sformatf("%s bl row%0d", tag, row), bl, exp_bl);
          if (row == 0) cap_bl0 = bl;
          step;
          chk($sformatf("%s wl hold row%0d", tag, row), wl, onehot(row));
          chk($sformatf("%s bl stable row%0d", tag, row), bl, exp_bl);
          step;
          chk($sformatf("%s wl low in hold row%0d", tag, row), wl, 0);
          chk($sformatf("%s bl hold row%0d", tag, row), bl, exp_bl);
          step;
          if (row == WL_W - 1) begin
`ifdef CFG_LOADER_CRC_EN
            chk({tag, " trailer ready"}, s_ready, 1);
            chk({tag, " done before trailer"}, cfg_done, 0);
`else
            chk({tag, " done"}, cfg_done, 1);
            chk({tag, " busy at done"}, busy, 0);
            chk({tag, " ready at done"}, s_ready, 0);
`endif
          end else begin
            chk($sformatf("%s ready next row%0d", tag, row), s_ready, 1);
          end
          row++;
        end else begin
          chk($sformatf("%s wl low loading beat%0d", tag, acc_n), wl, 0);
        end
      end
    end
    chk({tag, " rows completed"}, row, WL_W);
  endtask

  initial begin
    global_reset = 1'b1;
    start        = 1'b0;
    s_valid      = 1'b0;
    s_data       = '0;
    step;
    step;
    global_reset = 1'b0;
    repeat (10) step;
    chk("reset bl", bl, 0);
    chk("reset wl", wl, 0);
    chk("reset ready", s_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset done", cfg_done, 0);
    chk("reset error", cfg_error, 0);

    for (int b = 0; b < NBEATS; b++) beat_mem[b] = 16'hFFFF;
    do_load(1'b0, "ones");
    exp_bl = '1;
    chk("ones final bl", bl, exp_bl);
`ifdef CFG_LOADER_CRC_EN
    send_trailer("ones crc ok", crc_model(), 1'b0);
`endif

    do_load(1'b1, "gap");
    chk("gap final bl", bl, exp_bl);
`ifdef CFG_LOADER_CRC_EN
    send_trailer("gap crc bad", crc_model() ^ 16'h0001, 1'b1);
`endif

    beat_mem[0] = 16'h0001; beat_mem[1] = 16'h0000; beat_mem[2] = 16'hFF00;
    beat_mem[3] = 16'h1234; beat_mem[4] = 16'h5678; beat_mem[5] = 16'h9ABC;
    beat_mem[6] = 16'hDEF0; beat_mem[7] = 16'h0F0F; beat_mem[8] = 16'hF0F0;
    do_load(1'b0, "drop");
    exp_bl = '0;
    exp_bl[0] = 1'b1;
    chk("drop row0 only bit0", cap_bl0, exp_bl);
    chk("drop final keeps last row", bl, row_bits(2));
`ifdef CFG_LOADER_CRC_EN
    send_trailer("drop crc ok", crc_model(), 1'b0);
`endif

    start = 1'b1;
    step;
    start = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'hFFFF;
    repeat (9) step;
    s_valid = 1'b0;
    chk("pre-reset in row1 write", wl, onehot(1));
    global_reset = 1'b1;
    start        = 1'b1;
    step;
    global_reset = 1'b0;
    start        = 1'b0;
    chk("midreset wl", wl, 0);
    chk("midreset busy", busy, 0);
    chk("midreset bl", bl, 0);
    chk("midreset ready", s_ready, 0);
    chk("midreset done", cfg_done, 0);
    step;
    chk("start with reset ignored", busy, 0);
    do_load(1'b0, "reload");
`ifdef CFG_LOADER_CRC_EN
    send_trailer("reload crc ok", crc_model(), 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
